// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer blocks (relu_activation, max_pooling):
// the common job FSM encoding, Q16.16 constants and default widths.
package cnn_pkg;

  // Default widths shared by the layer blocks
  localparam int CNN_ADDR_WIDTH = 12;
  localparam int CNN_DATA_WIDTH = 32;
  localparam int CNN_DIM_WIDTH  = 4;

  // Q16.16 fixed-point constants
  localparam logic [31:0] Q16_ONE  = 32'h0001_0000;
  localparam logic [31:0] Q16_ZERO = 32'h0000_0000;

  // Job sequencing states common to the streaming layer blocks
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } cnn_state_t;

endpackage

// File: rtl/relu_unit.sv
// Single registered ReLU stage: clamps negative Q16.16 elements to zero,
// carries the element's write address alongside, and flags clamped elements.
module relu_unit #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  valid_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  neg_out
);

  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  neg_q;
  logic                  is_neg_s;

  // Sign bit alone decides clamping, so 0x80000000 (most negative) clamps too
  always_comb begin
    is_neg_s = data_in[DATA_WIDTH-1];
  end

  // Pipeline register: valid/neg always track the input; payload loads on valid
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      neg_q   <= 1'b0;
    end else begin
      valid_q <= valid_in;
      neg_q   <= valid_in & is_neg_s;
      if (valid_in) begin
        addr_q <= addr_in;
        data_q <= is_neg_s ? '0 : data_in;
      end
    end
  end

  assign valid_out = valid_q;
  assign addr_out  = addr_q;
  assign data_out  = data_q;
  assign neg_out   = neg_q;

endmodule

// File: rtl/relu_activation.sv
// In-memory ReLU over an N x N Q16.16 feature map. Streams one read per cycle
// from input_addr, clamps through relu_unit, and writes each result two cycles
// after its read to output_addr, so in-place operation is safe.
module relu_activation
  import cnn_pkg::*;
#(
  parameter int ADDR_WIDTH = CNN_ADDR_WIDTH,
  parameter int DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int DIM_WIDTH  = CNN_DIM_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_in,
  input  logic [ADDR_WIDTH-1:0]  input_addr,
  input  logic [ADDR_WIDTH-1:0]  output_addr,
  input  logic [DIM_WIDTH-1:0]   dimensions,
  output logic                   mem_rd_en,
  output logic [ADDR_WIDTH-1:0]  mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]  mem_rd_data,
  output logic                   mem_wr_en,
  output logic [ADDR_WIDTH-1:0]  mem_wr_addr,
  output logic [DATA_WIDTH-1:0]  mem_wr_data,
  output logic                   busy,
  output logic                   valid_out,
  output logic [2*DIM_WIDTH-1:0] neg_count
);

  cnn_state_t             state_q;
  logic                   rd_en_q;
  logic [ADDR_WIDTH-1:0]  rd_addr_q;
  logic [ADDR_WIDTH-1:0]  rd_addr_d;
  logic [2*DIM_WIDTH-1:0] total_q;
  logic [2*DIM_WIDTH-1:0] rd_cnt_q;
  logic [2*DIM_WIDTH-1:0] rd_cnt_d;
  logic                   busy_q;
  logic                   valid_out_q;
  logic                   rd_pend_q;
  logic [ADDR_WIDTH-1:0]  out_ptr_q;
  logic [ADDR_WIDTH-1:0]  out_ptr_d;
  logic [2*DIM_WIDTH-1:0] neg_count_q;
  logic [2*DIM_WIDTH-1:0] dim_ext_s;
  logic [2*DIM_WIDTH-1:0] total_s;
  logic                   start_s;
  logic                   relu_neg_s;

  // Element count, start detect and wrapping address/count increments
  always_comb begin
    dim_ext_s = {{DIM_WIDTH{1'b0}}, dimensions};
    total_s   = dim_ext_s * dim_ext_s;
    start_s   = (state_q == ST_IDLE) && valid_in;
    rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
    rd_cnt_d  = rd_cnt_q + (2*DIM_WIDTH)'(1);
    out_ptr_d = out_ptr_q + ADDR_WIDTH'(1);
  end

  // Job FSM: issues reads, waits for the write pipeline to drain, pulses done
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      total_q     <= '0;
      rd_cnt_q    <= '0;
      busy_q      <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_out_q <= 1'b0;
          if (valid_in) begin
            total_q <= total_s;
            if (dimensions == '0) begin
              state_q     <= ST_DONE;
              valid_out_q <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              state_q   <= ST_RUN;
              rd_en_q   <= 1'b1;
              rd_addr_q <= input_addr;
              rd_cnt_q  <= (2*DIM_WIDTH)'(1);
              busy_q    <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (rd_cnt_q == total_q) begin
            rd_en_q <= 1'b0;
            state_q <= ST_DRAIN;
          end else begin
            rd_addr_q <= rd_addr_d;
            rd_cnt_q  <= rd_cnt_d;
          end
        end
        ST_DRAIN: begin
          // Last read data is in flight while rd_pend_q is high; once it has
          // entered relu_unit its write is on the bus this cycle.
          if (!rd_pend_q) begin
            state_q     <= ST_DONE;
            valid_out_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        ST_DONE: begin
          valid_out_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q     <= ST_IDLE;
          rd_en_q     <= 1'b0;
          busy_q      <= 1'b0;
          valid_out_q <= 1'b0;
        end
      endcase
    end
  end

  // Read-return tracking and the output address that pairs with each element
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pend_q <= 1'b0;
      out_ptr_q <= '0;
    end else begin
      rd_pend_q <= rd_en_q;
      if (start_s) begin
        out_ptr_q <= output_addr;
      end else if (rd_pend_q) begin
        out_ptr_q <= out_ptr_d;
      end
    end
  end

  // Clamped-element counter, cleared on every accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      neg_count_q <= '0;
    end else if (start_s) begin
      neg_count_q <= '0;
    end else if (relu_neg_s) begin
      neg_count_q <= neg_count_q + (2*DIM_WIDTH)'(1);
    end
  end

  relu_unit #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_relu (
    .clk      (clk),
    .rst      (rst),
    .valid_in (rd_pend_q),
    .addr_in  (out_ptr_q),
    .data_in  (mem_rd_data),
    .valid_out(mem_wr_en),
    .addr_out (mem_wr_addr),
    .data_out (mem_wr_data),
    .neg_out  (relu_neg_s)
  );

  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign busy        = busy_q;
  assign valid_out   = valid_out_q;
  assign neg_count   = neg_count_q;

endmodule

// File: tb/tb_relu_activation.sv
// Directed bench for relu_activation: table of element values through an N=4
// job, plus hand-written sequences for timing, wrap, zero size, reset abort
// and a held start request.
module tb_relu_activation;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int NW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_in;
  logic [AW-1:0]   input_addr;
  logic [AW-1:0]   output_addr;
  logic [NW-1:0]   dimensions;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_rd_addr;
  logic [DW-1:0]   mem_rd_data = '0;
  logic            mem_wr_en;
  logic [AW-1:0]   mem_wr_addr;
  logic [DW-1:0]   mem_wr_data;
  logic            busy;
  logic            valid_out;
  logic [2*NW-1:0] neg_count;

  relu_activation #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DIM_WIDTH(NW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .input_addr(input_addr), .output_addr(output_addr), .dimensions(dimensions),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .valid_out(valid_out), .neg_count(neg_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: preloaded by the stimulus, read with one cycle latency
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (mem_rd_en === 1'b1) mem_rd_data <= mem[mem_rd_addr];
  end

  // Bus monitor, sampled mid-cycle
  int          rd_cyc_q[$];
  logic [11:0] rd_addr_log[$];
  int          wr_cyc_q[$];
  logic [11:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          vo_cyc_q[$];
  always @(negedge clk) begin
    if (mem_rd_en === 1'b1) begin
      rd_cyc_q.push_back(cyc);
      rd_addr_log.push_back(mem_rd_addr);
    end
    if (mem_wr_en === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      wr_addr_log.push_back(mem_wr_addr);
      wr_data_log.push_back(mem_wr_data);
    end
    if (valid_out === 1'b1) vo_cyc_q.push_back(cyc);
  end

  typedef struct {
    logic [31:0] din;
    logic [31:0] dexp;
    logic        neg;
  } vec_t;
  vec_t tab [16];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic start_job(input logic [11:0] ia, input logic [11:0] oa,
                           input logic [3:0] dim, input bit hold, output int t);
    @(negedge clk);
    input_addr  = ia;
    output_addr = oa;
    dimensions  = dim;
    valid_in    = 1'b1;
    t = cyc;
    @(negedge clk);
    if (!hold) valid_in = 1'b0;
  endtask

  task automatic wait_vo(input int base, input int budget, output int vc);
    vc = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      #1;
      if (vo_cyc_q.size() > base) begin
        vc = vo_cyc_q[base];
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, vc, rdb, wrb, vob, exp_neg, bad, late;

    tab[0]  = '{32'h0000_0000, 32'h0000_0000, 1'b0};
    tab[1]  = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0};
    tab[2]  = '{32'h8000_0000, 32'h0000_0000, 1'b1};
    tab[3]  = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    tab[4]  = '{32'h0001_0000, 32'h0001_0000, 1'b0};
    tab[5]  = '{32'hFFFF_0000, 32'h0000_0000, 1'b1};
    tab[6]  = '{32'h0000_0001, 32'h0000_0001, 1'b0};
    tab[7]  = '{32'h1234_5678, 32'h1234_5678, 1'b0};
    tab[8]  = '{32'hDEAD_BEEF, 32'h0000_0000, 1'b1};
    tab[9]  = '{32'h4000_0000, 32'h4000_0000, 1'b0};
    tab[10] = '{32'hC000_0000, 32'h0000_0000, 1'b1};
    tab[11] = '{32'h7FFF_0000, 32'h7FFF_0000, 1'b0};
    tab[12] = '{32'h8000_0001, 32'h0000_0000, 1'b1};
    tab[13] = '{32'h0000_FFFF, 32'h0000_FFFF, 1'b0};
    tab[14] = '{32'hFFFF_FFFE, 32'h0000_0000, 1'b1};
    tab[15] = '{32'h0000_8000, 32'h0000_8000, 1'b0};

    for (int i = 0; i < 4096; i++) mem[12'(i)] = 32'h0;
    rst = 1'b1; valid_in = 1'b0;
    input_addr = 12'h000; output_addr = 12'h000; dimensions = 4'd0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_rd_en", 32'(mem_rd_en), 32'h0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_valid_out", 32'(valid_out), 32'h0);
    chk("rst_neg_count", 32'(neg_count), 32'h0);
    chk("rst_rd_addr", 32'(mem_rd_addr), 32'h0);
    chk("rst_wr_addr", 32'(mem_wr_addr), 32'h0);
    chk("rst_wr_data", mem_wr_data, 32'h0);
    rst = 1'b0;

    // Basic N=2 job with mid-job input noise
    mem[12'h100] = 32'h0001_0000; mem[12'h101] = 32'hFFFF_0000;
    mem[12'h102] = 32'h0000_0000; mem[12'h103] = 32'h8000_0000;
    rdb = rd_cyc_q.size(); wrb = wr_cyc_q.size(); vob = vo_cyc_q.size();
    start_job(12'h100, 12'h200, 4'd2, 1'b0, t);
    #1;
    chk("b_busy_run", 32'(busy), 32'h1);
    input_addr = 12'h555; output_addr = 12'h666; dimensions = 4'd7;
    @(negedge clk); valid_in = 1'b1;
    @(negedge clk); valid_in = 1'b0;
    wait_vo(vob, 20, vc);
    chk("b_vo_cycle", 32'(vc), 32'(t + 7));
    chk("b_busy_done", 32'(busy), 32'h0);
    chk("b_neg_count", 32'(neg_count), 32'h2);
    chk("b_nwr", 32'(wr_cyc_q.size() - wrb), 32'h4);
    for (int i = 0; i < 4; i++) begin
      if (wrb + i < wr_cyc_q.size()) begin
        chk("b_wr_addr", 32'(wr_addr_log[wrb+i]), 32'(12'h200 + 12'(i)));
        chk("b_wr_cyc", 32'(wr_cyc_q[wrb+i]), 32'(t + 3 + i));
      end
    end
    if (wrb + 3 < wr_cyc_q.size()) begin
      chk("b_wr_d0", wr_data_log[wrb], 32'h0001_0000);
      chk("b_wr_d1", wr_data_log[wrb+1], 32'h0);
      chk("b_wr_d3", wr_data_log[wrb+3], 32'h0);
    end
    chk("b_nrd", 32'(rd_cyc_q.size() - rdb), 32'h4);
    if (rdb < rd_cyc_q.size()) chk("b_rd_first_cyc", 32'(rd_cyc_q[rdb]), 32'(t + 1));

    // N=0: no memory traffic, immediate completion
    rdb = rd_cyc_q.size(); wrb = wr_cyc_q.size(); vob = vo_cyc_q.size();
    start_job(12'h100, 12'h200, 4'd0, 1'b0, t);
    wait_vo(vob, 5, vc);
    chk("z_vo_cycle", 32'(vc), 32'(t + 1));
    chk("z_neg_count", 32'(neg_count), 32'h0);
    repeat (4) @(negedge clk);
    #1;
    chk("z_nrd", 32'(rd_cyc_q.size() - rdb), 32'h0);
    chk("z_nwr", 32'(wr_cyc_q.size() - wrb), 32'h0);

    // Table-driven element vectors, N=4
    exp_neg = 0;
    for (int i = 0; i < 16; i++) begin
      mem[12'h300 + 12'(i)] = tab[4'(i)].din;
      exp_neg += int'(tab[4'(i)].neg);
    end
    rdb = rd_cyc_q.size(); wrb = wr_cyc_q.size(); vob = vo_cyc_q.size();
    start_job(12'h300, 12'h400, 4'd4, 1'b0, t);
    wait_vo(vob, 40, vc);
    chk("t_vo_cycle", 32'(vc), 32'(t + 19));
    chk("t_neg_count", 32'(neg_count), 32'(exp_neg));
    chk("t_nwr", 32'(wr_cyc_q.size() - wrb), 32'd16);
    chk("t_nrd", 32'(rd_cyc_q.size() - rdb), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (wrb + i < wr_cyc_q.size()) begin
        chk("t_wr_data", wr_data_log[wrb+i], tab[4'(i)].dexp);
        chk("t_wr_addr", 32'(wr_addr_log[wrb+i]), 32'(12'h400 + 12'(i)));
        chk("t_wr_cyc", 32'(wr_cyc_q[wrb+i]), 32'(t + 3 + i));
      end
      if (rdb + i < rd_cyc_q.size()) begin
        chk("t_rd_addr", 32'(rd_addr_log[rdb+i]), 32'(12'h300 + 12'(i)));
      end
    end

    // Address wrap at the top of the map
    mem[12'hFFE] = 32'h0000_0011; mem[12'hFFF] = 32'h8000_0022;
    mem[12'h000] = 32'h0000_0033; mem[12'h001] = 32'h0000_0044;
    rdb = rd_cyc_q.size(); wrb = wr_cyc_q.size(); vob = vo_cyc_q.size();
    start_job(12'hFFE, 12'hFFF, 4'd2, 1'b0, t);
    wait_vo(vob, 20, vc);
    chk("w_vo_cycle", 32'(vc), 32'(t + 7));
    if (rdb + 3 < rd_cyc_q.size() && wrb + 3 < wr_cyc_q.size()) begin
      chk("w_rd0", 32'(rd_addr_log[rdb]),   32'h0FFE);
      chk("w_rd1", 32'(rd_addr_log[rdb+1]), 32'h0FFF);
      chk("w_rd2", 32'(rd_addr_log[rdb+2]), 32'h0000);
      chk("w_rd3", 32'(rd_addr_log[rdb+3]), 32'h0001);
      chk("w_wr0", 32'(wr_addr_log[wrb]),   32'h0FFF);
      chk("w_wr1", 32'(wr_addr_log[wrb+1]), 32'h0000);
      chk("w_wr2", 32'(wr_addr_log[wrb+2]), 32'h0001);
      chk("w_wr3", 32'(wr_addr_log[wrb+3]), 32'h0002);
      chk("w_wd2", wr_data_log[wrb+2], 32'h0000_0033);
    end else begin
      chk("w_traffic_count", 32'(rd_cyc_q.size() - rdb), 32'h4);
    end

    // In-place operation
    mem[12'h500] = 32'h8000_0000; mem[12'h501] = 32'h0000_0005;
    mem[12'h502] = 32'hFFFF_FFFF; mem[12'h503] = 32'h0000_0007;
    wrb = wr_cyc_q.size(); vob = vo_cyc_q.size();
    start_job(12'h500, 12'h500, 4'd2, 1'b0, t);
    wait_vo(vob, 20, vc);
    chk("ip_vo_cycle", 32'(vc), 32'(t + 7));
    chk("ip_neg_count", 32'(neg_count), 32'h2);
    if (wrb + 3 < wr_cyc_q.size()) begin
      chk("ip_wd0", wr_data_log[wrb],   32'h0);
      chk("ip_wd1", wr_data_log[wrb+1], 32'h5);
      chk("ip_wd3", wr_data_log[wrb+3], 32'h7);
    end else begin
      chk("ip_nwr", 32'(wr_cyc_q.size() - wrb), 32'h4);
    end

    // Reset mid-job aborts, then a fresh job completes
    mem[12'h600] = 32'h0000_0011; mem[12'h601] = 32'h8000_0000; mem[12'h602] = 32'h0000_0022;
    wrb = wr_cyc_q.size(); vob = vo_cyc_q.size();
    start_job(12'h600, 12'h700, 4'd3, 1'b0, t);
    for (int k = 0; k < 10; k++) begin
      if (cyc == t + 3) break;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ra_rd_en", 32'(mem_rd_en), 32'h0);
    chk("ra_wr_en", 32'(mem_wr_en), 32'h0);
    chk("ra_busy", 32'(busy), 32'h0);
    chk("ra_valid_out", 32'(valid_out), 32'h0);
    chk("ra_neg_count", 32'(neg_count), 32'h0);
    chk("ra_rd_addr", 32'(mem_rd_addr), 32'h0);
    chk("ra_wr_addr", 32'(mem_wr_addr), 32'h0);
    chk("ra_wr_data", mem_wr_data, 32'h0);
    repeat (10) @(negedge clk);
    #1;
    late = 0;
    for (int i = wrb; i < wr_cyc_q.size(); i++) if (wr_cyc_q[i] >= t + 4) late++;
    chk("ra_late_writes", 32'(late), 32'h0);
    chk("ra_no_vo", 32'(vo_cyc_q.size() - vob), 32'h0);
    wrb = wr_cyc_q.size(); vob = vo_cyc_q.size();
    start_job(12'h602, 12'h710, 4'd1, 1'b0, t2);
    wait_vo(vob, 10, vc);
    chk("ra_new_vo", 32'(vc), 32'(t2 + 4));
    chk("ra_new_nwr", 32'(wr_cyc_q.size() - wrb), 32'h1);
    if (wrb < wr_cyc_q.size()) begin
      chk("ra_new_waddr", 32'(wr_addr_log[wrb]), 32'h0710);
      chk("ra_new_wdata", wr_data_log[wrb], 32'h0000_0022);
    end

    // valid_in held high across a full N=15 job
    for (int i = 0; i < 225; i++)
      mem[12'(i)] = (i % 2 == 1) ? (32'h8000_0000 | 32'(i)) : 32'(i);
    rdb = rd_cyc_q.size(); wrb = wr_cyc_q.size(); vob = vo_cyc_q.size();
    start_job(12'h000, 12'h800, 4'd15, 1'b1, t);
    wait_vo(vob, 300, vc);
    chk("h_vo_cycle", 32'(vc), 32'(t + 228));
    chk("h_neg_count", 32'(neg_count), 32'd112);
    chk("h_single_vo", 32'(vo_cyc_q.size() - vob), 32'h1);
    @(negedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    wait_vo(vob + 1, 300, vc);
    chk("h_vo2_cycle", 32'(vc), 32'(t + 457));
    bad = 0;
    for (int i = 0; i < 225; i++) begin
      if (rdb + i >= rd_cyc_q.size() || wrb + i >= wr_cyc_q.size()) bad++;
      else begin
        if (rd_cyc_q[rdb+i] != t + 1 + i || rd_addr_log[rdb+i] != 12'(i)) bad++;
        if (wr_cyc_q[wrb+i] != t + 3 + i || wr_addr_log[wrb+i] != 12'h800 + 12'(i)) bad++;
        if (wr_data_log[wrb+i] != ((i % 2 == 1) ? 32'h0 : 32'(i))) bad++;
      end
    end
    chk("h_stream_errors", 32'(bad), 32'h0);
    chk("h_total_rd", 32'(rd_cyc_q.size() - rdb), 32'd450);
    if (rdb + 225 < rd_cyc_q.size()) chk("h_job2_first_rd", 32'(rd_cyc_q[rdb+225]), 32'(t + 230));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/relu_activation.md
RELU_ACTIVATION -- requirements
Module: relu_activation

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, SHALL set the memory address width.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the element width; elements are signed Q16.16.
REQ-003 Parameter DIM_WIDTH, default 4, SHALL set the width of the square-map dimension.
REQ-004 Port clk, input, 1: SHALL be the single clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: SHALL be the reset, synchronous and active-high.
REQ-006 Port valid_in, input, 1: SHALL be the start request, sampled only in IDLE.
REQ-007 Port input_addr, input, ADDR_WIDTH: SHALL give the base address of the feature map to be read.
REQ-008 Port output_addr, input, ADDR_WIDTH: SHALL give the base address for the activated feature map, which max_pooling consumes.
REQ-009 Port dimensions, input, DIM_WIDTH: SHALL give the map side N; the element count is N*N.
REQ-010 Port mem_rd_en, output, 1: SHALL be the read strobe.
REQ-011 Port mem_rd_addr, output, ADDR_WIDTH: SHALL be the read address.
REQ-012 Port mem_rd_data, input, DATA_WIDTH: SHALL be the read data, valid exactly 1 cycle after mem_rd_en.
REQ-013 Port mem_wr_en, output, 1: SHALL be the write strobe.
REQ-014 Port mem_wr_addr, output, ADDR_WIDTH: SHALL be the write address.
REQ-015 Port mem_wr_data, output, DATA_WIDTH: SHALL be the write data.
REQ-016 Port busy, output, 1: SHALL be high from the cycle after an accepted start until valid_out.
REQ-017 Port valid_out, output, 1: SHALL be a 1-cycle completion pulse.
REQ-018 Port neg_count, output, 2*DIM_WIDTH: SHALL hold the number of elements clamped in the last job.

Function
REQ-019 FSM states SHALL be IDLE, RUN, DRAIN and DONE.
REQ-020 IDLE with valid_in=1: the block SHALL latch input_addr, output_addr and N*N (2*DIM_WIDTH bits), clear neg_count, and go to RUN.
REQ-021 IDLE with valid_in=1 and dimensions=0: the block SHALL go directly to DONE with no memory access.
REQ-022 RUN SHALL issue one read per cycle at input_addr+i, i=0..N*N-1, then go to DRAIN after the last read.
REQ-023 The write for element i SHALL occur 2 cycles after its read: mem_wr_addr=output_addr+i, mem_wr_data=0 if bit DATA_WIDTH-1 of the data is set, else the data unchanged.
REQ-024 neg_count SHALL increment on each clamped element.
REQ-025 DRAIN SHALL complete the outstanding writes, then go to DONE.
REQ-026 DONE SHALL assert valid_out for 1 cycle with busy low, then return to IDLE.
REQ-027 Latency: with the start accepted at cycle T and n=N*N, reads SHALL occur at T+1..T+n, writes at T+3..T+2+n, and valid_out at T+3+n.
REQ-028 Sustained throughput SHALL be 1 element per cycle, with no bubbles.
REQ-029 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-030 valid_in outside IDLE SHALL be ignored, and input changes during a job SHALL have no effect.
REQ-031 mem_rd_en and mem_wr_en MAY both be high in the same cycle; in-place operation (input_addr=output_addr) SHALL be correct because each write trails its read.
REQ-032 Zero and 0x7FFFFFFF SHALL pass unchanged; 0x80000000 SHALL become 0.

Reset
REQ-033 When rst=1, the state SHALL go to IDLE, and mem_rd_en, mem_wr_en, busy, valid_out, neg_count, the addresses, mem_wr_data and all counters SHALL be cleared to 0.
REQ-034 Reset mid-job SHALL abort the job: no write SHALL occur in the cycle after rst, and the block SHALL not produce valid_out for the aborted job.

Structure
REQ-035 A shared package cnn_pkg SHALL hold the FSM state encoding, the Q16.16 constants (ONE=32'h00010000, ZERO) and the default widths, for reuse by max_pooling.
REQ-036 A sub-module relu_unit SHALL be used: a registered 1-stage clamp with a negative flag output.

Verification
REQ-037 N=2, input_addr=0x100, output_addr=0x200, data {0x00010000, 0xFFFF0000, 0, 0x80000000} -> writes {0x00010000, 0, 0, 0} at 0x200..0x203, neg_count=2, valid_out at T+7.
REQ-038 N=0 start -> no rd_en or wr_en, valid_out at T+1, neg_count=0.
REQ-039 input_addr=0xFFE, output_addr=0xFFF, N=2 -> reads 0xFFE, 0xFFF, 0x000, 0x001; writes 0xFFF, 0x000, 0x001, 0x002.
REQ-040 rst asserted at T+3 of an N=3 job -> all outputs 0 from T+4, no writes and no valid_out afterwards; a new start then completes normally.
REQ-041 valid_in held high for a whole N=15 job -> exactly one job, 225 reads and 225 writes on consecutive cycles, valid_out at T+228, the next job starting from the following IDLE cycle.
